// File: rtl/vga_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_vram_arbiter
//  Purpose  : Shares the single-port character RAM between the VGA pixel
//             reader (absolute priority) and the RTC display writer, whose
//             writes are buffered in a small FIFO and drained in idle or
//             blanking cycles.
//  Revision : 1.0  initial release
// ============================================================================
module vga_vram_arbiter #(
    parameter int AW            = 12,
    parameter int DW            = 8,
    parameter int DEPTH         = 4,
    parameter int WR_BLANK_ONLY = 1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     video_on,
    input  logic                     vblank,
    input  logic                     rd_req,
    input  logic [AW-1:0]            rd_addr,
    output logic                     rd_valid,
    output logic [DW-1:0]            rd_data,
    input  logic                     wr_req,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_data,
    output logic                     wr_ready,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [AW-1:0]            ram_addr,
    output logic [DW-1:0]            ram_wdata,
    input  logic [DW-1:0]            ram_rdata,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     ovf_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_rd   = 2'd1;
    localparam logic [1:0] c_st_wr   = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;
    logic          r_rd_valid;
    logic          r_ovf;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [AW-1:0] r_fifo_addr [DEPTH];
    logic [DW-1:0] r_fifo_data [DEPTH];

    logic          w_window;
    logic          w_wr_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    // video_on is part of the display timing bundle but arbitration keys off
    // rd_req and vblank only.
    assign w_unused = video_on;

    // Write window: blanking-only or any cycle without a pixel read.
    generate
        if (WR_BLANK_ONLY != 0) begin : g_window_blank
            assign w_window = vblank;
        end else begin : g_window_open
            assign w_window = 1'b1;
        end
    endgenerate

    assign w_wr_ready = (r_count < c_depth);
    assign w_push     = wr_req && w_wr_ready;

    // Arbitration: pixel read first, then a FIFO pop inside the write window.
    // Uses the pre-push count so a fresh entry is never bypassed out.
    always_comb begin
        w_next_state = c_st_idle;
        w_pop        = 1'b0;
        if (rd_req) begin
            w_next_state = c_st_rd;
        end else if ((r_count != '0) && w_window) begin
            w_next_state = c_st_wr;
            w_pop        = 1'b1;
        end
    end

    // Grant register, RAM port address/data, read-valid pipeline, overflow flag.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= c_st_idle;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rd_valid  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_rd_valid <= (r_state == c_st_rd);
            if (w_next_state == c_st_rd) begin
                r_ram_addr <= rd_addr;
            end else if (w_next_state == c_st_wr) begin
                r_ram_addr  <= r_fifo_addr[r_rptr];
                r_ram_wdata <= r_fifo_data[r_rptr];
            end
            if (wr_req && !w_wr_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while the count says empty.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= wr_addr;
            r_fifo_data[r_wptr] <= wr_data;
        end
    end

    assign ram_en     = (r_state != c_st_idle);
    assign ram_we     = (r_state == c_st_wr);
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = ram_rdata;
    assign wr_ready   = w_wr_ready;
    assign fifo_count = r_count;
    assign ovf_err    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_vga_vram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_vga_vram_arbiter
//  Purpose  : Self-checking bench for vga_vram_arbiter; one instance with
//             blanking-only writes, one with open write window, both fed the
//             same stimulus and compared to a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_vram_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          video_on, vblank, rd_req, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;

    logic          rd_valid   [2];
    logic [DW-1:0] rd_data    [2];
    logic          wr_ready   [2];
    logic          ram_en     [2];
    logic          ram_we     [2];
    logic [AW-1:0] ram_addr   [2];
    logic [DW-1:0] ram_wdata  [2];
    logic [DW-1:0] ram_rdata  [2];
    logic [CW-1:0] fifo_count [2];
    logic          ovf_err    [2];

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    vga_vram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WR_BLANK_ONLY(1)) u_dut_blank (
        .CLK(CLK), .RESET_N(RESET_N), .video_on(video_on), .vblank(vblank),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready[0]),
        .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
        .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]),
        .fifo_count(fifo_count[0]), .ovf_err(ovf_err[0])
    );

    vga_vram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WR_BLANK_ONLY(0)) u_dut_open (
        .CLK(CLK), .RESET_N(RESET_N), .video_on(video_on), .vblank(vblank),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready[1]),
        .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
        .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]),
        .fifo_count(fifo_count[1]), .ovf_err(ovf_err[1])
    );

    // Synchronous single-port RAMs; unwritten cells read back addr[7:0].
    bit [7:0] tram [2][4096];
    bit       tw   [2][4096];
    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_en[k]) begin
                if (ram_we[k]) begin
                    tram[k][ram_addr[k]] <= ram_wdata[k];
                    tw[k][ram_addr[k]]   <= 1'b1;
                end else begin
                    ram_rdata[k] <= tw[k][ram_addr[k]] ? tram[k][ram_addr[k]] : ram_addr[k][7:0];
                end
            end
        end
    end

    // ---------------- reference model ----------------
    wr_t           mq0[$];
    wr_t           mq1[$];
    bit [7:0]      mram [2][4096];
    bit            mw   [2][4096];
    logic          e_en  [2], e_we [2], e_ovf [2], e_rdv [2];
    logic [AW-1:0] e_addr[2];
    logic [DW-1:0] e_wd  [2], e_rdd[2];
    int            e_cnt [2];
    bit            p_rdv [2];
    logic [DW-1:0] p_rdd [2];

    function automatic int qsize(int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic wr_t qpop(int k);
        if (k == 0) return mq0.pop_front();
        return mq1.pop_front();
    endfunction

    function automatic void qpush(int k, wr_t e);
        if (k == 0) mq0.push_back(e);
        else        mq1.push_back(e);
    endfunction

    function automatic logic [7:0] mread(int k, logic [AW-1:0] a);
        logic [AW-1:0] aa;
        aa = a;
        return mw[k][aa] ? mram[k][aa] : aa[7:0];
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int k = 0; k < 2; k++) begin
            e_en[k] = 0; e_we[k] = 0; e_ovf[k] = 0; e_rdv[k] = 0;
            e_addr[k] = '0; e_wd[k] = '0; e_rdd[k] = '0; e_cnt[k] = 0;
            p_rdv[k] = 0; p_rdd[k] = '0;
        end
    endtask

    // One clock edge of the arbiter as described behaviourally.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int  n;
            bit  w;
            wr_t e;
            n = qsize(k);
            w = (k == 0) ? vblank : 1'b1;
            e_rdv[k] = p_rdv[k];
            e_rdd[k] = p_rdd[k];
            p_rdv[k] = 0;
            if (rd_req) begin
                e_en[k] = 1; e_we[k] = 0; e_addr[k] = rd_addr;
                p_rdv[k] = 1; p_rdd[k] = mread(k, rd_addr);
            end else if (n > 0 && w) begin
                e = qpop(k);
                e_en[k] = 1; e_we[k] = 1; e_addr[k] = e.a; e_wd[k] = e.d;
                mram[k][e.a] = e.d;
                mw[k][e.a]   = 1;
            end else begin
                e_en[k] = 0; e_we[k] = 0;
            end
            if (wr_req) begin
                if (n < DEPTH) begin
                    e.a = wr_addr; e.d = wr_data;
                    qpush(k, e);
                end else begin
                    e_ovf[k] = 1;
                end
            end
            e_cnt[k] = qsize(k);
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] t=%0t observed=%h expected=%h", tag, k, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("ram_en",     k, 32'(ram_en[k]),     32'(e_en[k]));
            chk("ram_we",     k, 32'(ram_we[k]),     32'(e_we[k]));
            chk("ram_addr",   k, 32'(ram_addr[k]),   32'(e_addr[k]));
            chk("ram_wdata",  k, 32'(ram_wdata[k]),  32'(e_wd[k]));
            chk("fifo_count", k, 32'(fifo_count[k]), 32'(e_cnt[k]));
            chk("wr_ready",   k, 32'(wr_ready[k]),   32'(e_cnt[k] < DEPTH));
            chk("ovf_err",    k, 32'(ovf_err[k]),    32'(e_ovf[k]));
            chk("rd_valid",   k, 32'(rd_valid[k]),   32'(e_rdv[k]));
            if (e_rdv[k]) chk("rd_data", k, 32'(rd_data[k]), 32'(e_rdd[k]));
        end
    endtask

    task automatic tick();
        if (RESET_N) model_edge();
        else         model_reset();
        @(posedge CLK);
        @(negedge CLK);
        check_all();
    endtask

    task automatic set_in(input bit rr, input int ra, input bit wr, input int wa, input int wd);
        rd_req  = rr;
        rd_addr = AW'(ra);
        wr_req  = wr;
        wr_addr = AW'(wa);
        wr_data = DW'(wd);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RESET_N  = 1'b0;
        vblank   = 1'b0;
        video_on = 1'b1;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        @(negedge CLK);
        check_all();
        tick();
        RESET_N = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 20; i++) tick();

        // Five back-to-back reads of preloaded cells 0..4.
        for (int i = 0; i < 5; i++) begin
            set_in(1, i, 0, 0, 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();

        // Fill the FIFO outside blanking, then one push too many.
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 1, 'h100 + i, 'h30 + i);
            tick();
        end
        set_in(0, 0, 1, 'h1FF, 'hEE);
        tick();
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();

        // Blanking drains the buffered writes in order.
        vblank   = 1'b1;
        video_on = 1'b0;
        for (int i = 0; i < 7; i++) tick();

        // Read back what was written.
        for (int i = 0; i < 5; i++) begin
            set_in(1, 'h100 + i, 0, 0, 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        vblank   = 1'b0;
        video_on = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // One pending write while reads come on alternate cycles.
        set_in(1, 'h010, 1, 'h010, 'hA5);
        tick();
        for (int i = 0; i < 8; i++) begin
            set_in((i % 2) == 1, 'h010 + i, 0, 0, 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();

        // Randomised traffic over a small address range.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) vblank = ~vblank;
            video_on = ~vblank;
            set_in($urandom_range(0, 1) == 1, 'h100 + $urandom_range(0, 15),
                   $urandom_range(0, 2) == 0, 'h100 + $urandom_range(0, 15),
                   $urandom_range(0, 255));
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        vblank = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Mid-operation reset: three writes queued and a read in flight.
        vblank = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 'h020 + i, 1, 'h200 + i, 'h60 + i);
            tick();
        end
        set_in(1, 'h023, 0, 0, 0);
        tick();
        set_in(1, 'h024, 1, 'h203, 'h63);
        tick();
        set_in(0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 1, 'h204, 'h64);
        tick();
        set_in(0, 0, 0, 0, 0);
        set_in(1, 'h025, 0, 0, 0);
        tick();
        #2;
        RESET_N = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge CLK);
        @(negedge CLK);
        check_all();
        RESET_N = 1'b1;
        set_in(0, 0, 0, 0, 0);
        vblank = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Shares the single-port character/video RAM between two requesters.
  - The VGA pixel generator reads it, driven by the 640x480 sync timing (pixel_x/pixel_y, video_on).
  - The RTC display-update writer writes time/date characters into it.
- Pixel reads have absolute priority.
- Writes are buffered in a small FIFO and drained in gaps or blanking, so RTC updates never corrupt or stall scan-out.

Parameters:
AW, 12, RAM address width (80x30 text = 2400 cells)
DW, 8, RAM data width
DEPTH, 4, write FIFO depth (power of 2, >=2)
WR_BLANK_ONLY, 1, 1 = writes drained only during vertical blanking; 0 = whenever no read is requested

Ports:
CLK  in  1  system clock (100 MHz)
RESET_N  in  1  asynchronous active-low reset
video_on  in  1  high inside 640x480 active area
vblank  in  1  high when pixel_y >= 480
rd_req  in  1  pixel generator read request, single-cycle per address
rd_addr  in  AW  read address
rd_valid  out  1  read data valid strobe
rd_data  out  DW  read data
wr_req  in  1  RTC writer push request
wr_addr  in  AW  write address
wr_data  in  DW  write data
wr_ready  out  1  FIFO can accept a push
ram_en  out  1  RAM port enable
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data (synchronous, 1-cycle latency)
fifo_count  out  clog2(DEPTH)+1  FIFO occupancy
ovf_err  out  1  sticky: push attempted while full

Behaviour:
- Reset (RESET_N=0, async):
  - FIFO emptied; fifo_count=0, wr_ready=1.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - rd_valid=0, ovf_err=0, state=IDLE.
  - Asserted mid-operation: in-flight read and buffered writes are discarded, with no partial RAM write; the first RAM access after release is a new grant.
- Push:
  - Accepted when wr_req && wr_ready; wr_ready = (fifo_count < DEPTH).
  - No bypass: a pushed entry is poppable the following cycle at the earliest.
  - wr_req while full: ignored, and ovf_err sets and holds until reset.
- Write window W:
  - WR_BLANK_ONLY=1: W = vblank.
  - WR_BLANK_ONLY=0: W = 1.
- Arbitration, evaluated every CLK, first match wins:
  1. rd_req=1 -> grant READ.
  2. fifo_count>0 && W -> grant WRITE (pop head).
  3. Otherwise IDLE.
- State register: IDLE / RD / WR holds the registered grant; it drives the RAM port one cycle after arbitration.
  - RD: ram_en=1, ram_we=0, ram_addr=captured rd_addr.
  - WR: ram_en=1, ram_we=1, ram_addr/ram_wdata = popped entry.
  - IDLE: ram_en=0, ram_we=0; ram_addr and ram_wdata hold their last values.
- Read latency:
  - rd_req at cycle t -> RAM port at t+1 -> rd_valid=1 and rd_data=ram_rdata at t+2.
  - Back-to-back rd_req every cycle is supported at full throughput.
  - rd_data outside rd_valid is don't-care.
- Simultaneous push and pop in one cycle: both take effect; fifo_count is unchanged.
- FIFO pointers wrap modulo DEPTH; fifo_count saturates neither way (overflow is blocked by wr_ready, underflow by arbitration).
- FIFO order is strict; each entry is written exactly once.
- A write is never issued in a cycle where rd_req=1, regardless of W.
- With rd_req=1 continuously and W=1, writes starve. This is acceptable: the pixel generator drops rd_req outside video_on.

Test Plan:
- Reset release, no requests -> ram_en=0, wr_ready=1, fifo_count=0, rd_valid=0 for 20 cycles.
- rd_req for addr 0x000..0x004 on 5 consecutive cycles, RAM preloaded data=addr[7:0] -> rd_valid high at cycles t+2..t+6 with rd_data 0x00..0x04, ram_we never 1.
- WR_BLANK_ONLY=1, vblank=0, push 4 writes (0x100/0x30..0x103/0x33) -> fifo_count=4, wr_ready=0, no RAM write.
  - Then vblank=1 -> 4 consecutive ram_we pulses in order, fifo_count returns to 0.
- Full FIFO plus 5th wr_req -> push ignored, ovf_err=1 and stays 1 after the FIFO drains.
- WR_BLANK_ONLY=0, one pending write, rd_req pulses on alternate cycles -> writes occupy only the cycles following rd_req=0; read data stays correct with latency 2.
- RESET_N low for 1 cycle with 3 writes queued and a read in flight -> rd_valid stays 0, fifo_count=0, no ram_we after release, ovf_err=0.
